// File: rtl/apb_pkg.sv
// Shared definitions for the APB completer register bank:
// FSM encodings, response codes and width helpers.
package apb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic OKAY   = 1'b0;
  localparam logic SLVERR = 1'b1;

  // Byte lanes in a data word.
  function automatic int strb_width(int dw);
    return dw / 8;
  endfunction

  // Register index width, never narrower than one bit.
  function automatic int idx_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_strb_reg.sv
// One data register with per-byte write enables.
// Lanes without a strobe keep their previous value.
module apb_strb_reg
  import apb_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter logic [DataWidth-1:0] ResetVal = '0
) (
  input  logic                            PCLK,
  input  logic                            PRESETn,
  input  logic                            en,
  input  logic [strb_width(DataWidth)-1:0] strb,
  input  logic [DataWidth-1:0]            d,
  output logic [DataWidth-1:0]            q
);

  localparam int StrbWidth = strb_width(DataWidth);

  // Byte-lane update on a write enable.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      q <= ResetVal;
    end else if (en) begin
      for (int i = 0; i < StrbWidth; i++) begin
        if (strb[i]) q[i*8 +: 8] <= d[i*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/apb_completer_regs.sv
// APB completer owning a bank of read/write registers with
// byte strobes, programmable wait states and error response.
module apb_completer_regs
  import apb_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32,
  parameter int NumRegs   = 8,
  parameter logic [DataWidth-1:0] ResetVal = '0
) (
  input  logic                            PCLK,
  input  logic                            PRESETn,
  input  logic                            PSEL,
  input  logic                            PENABLE,
  input  logic                            PWRITE,
  input  logic [AddrWidth-1:0]            PADDR,
  input  logic [DataWidth-1:0]            PWDATA,
  input  logic [strb_width(DataWidth)-1:0] PSTRB,
  input  logic [3:0]                      WaitCfg,
  output logic                            PREADY,
  output logic [DataWidth-1:0]            PRDATA,
  output logic                            PSLVERR,
  output logic [NumRegs*DataWidth-1:0]    RegFile,
  output logic [NumRegs-1:0]              WrPulse
);

  localparam int IdxWidth = idx_width(NumRegs);

  state_t                state;
  logic [3:0]            cnt;
  logic                  legal;
  logic [IdxWidth-1:0]   idx;
  logic [NumRegs-1:0]    we;
  logic [DataWidth-1:0]  regs [NumRegs];

  // Full-width range check so upper address bits cannot alias.
  assign idx   = PADDR[IdxWidth+1:2];
  assign legal = (PADDR[1:0] == 2'b00) &&
                 ((PADDR >> 2) < AddrWidth'(NumRegs));

  assign PREADY  = (state == ACCESS) && (cnt == 4'd0) &&
                   PSEL && PENABLE;
  assign PSLVERR = (PREADY && !legal) ? SLVERR : OKAY;

  // Read mux, forced to zero outside a legal read completion.
  always_comb begin
    PRDATA = '0;
    if (PREADY && legal && !PWRITE) PRDATA = regs[idx];
  end

  for (genvar k = 0; k < NumRegs; k++) begin : g_reg
    assign we[k] = PREADY && PWRITE && legal &&
                   (idx == IdxWidth'(k));

    apb_strb_reg #(
      .DataWidth (DataWidth),
      .ResetVal  (ResetVal)
    ) u_reg (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .en      (we[k]),
      .strb    (PSTRB),
      .d       (PWDATA),
      .q       (regs[k])
    );

    assign RegFile[k*DataWidth +: DataWidth] = regs[k];
  end

  // Transfer FSM with wait counter; write pulse follows the
  // completing edge by one cycle.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      WrPulse <= '0;
    end else begin
      WrPulse <= we;
      unique case (state)
        IDLE: begin
          if (PSEL && !PENABLE) begin
            state <= ACCESS;
            cnt   <= WaitCfg;
          end
        end
        ACCESS: begin
          if (!PSEL) begin
            state <= IDLE;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (PENABLE) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_completer_regs.sv
// Scoreboard bench for apb_completer_regs: stimulus queues the
// expected response, a negedge monitor checks each completion.
module tb_apb_completer_regs;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [31:0] PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic [3:0]  PSTRB = '0;
  logic [3:0]  WaitCfg = '0;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;
  logic [255:0] RegFile;
  logic [7:0]  WrPulse;

  apb_completer_regs #(
    .DataWidth (32),
    .AddrWidth (32),
    .NumRegs   (8),
    .ResetVal  (32'h0)
  ) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PSTRB   (PSTRB),
    .WaitCfg (WaitCfg),
    .PREADY  (PREADY),
    .PRDATA  (PRDATA),
    .PSLVERR (PSLVERR),
    .RegFile (RegFile),
    .WrPulse (WrPulse)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic        wr;
    logic [31:0] rdata;
    logic        err;
    int          waits;
    logic [7:0]  pulse;
  } exp_t;

  exp_t q[$];
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  int   cyc = 0;

  always @(posedge PCLK) cyc++;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // Issue one transfer; er is the hand-computed read data.
  task automatic xfer(bit wr, logic [31:0] a, logic [31:0] d,
                      logic [3:0] s, logic [3:0] w, bit chg,
                      logic [31:0] er);
    exp_t e;
    bit   lg;
    lg      = (a[1:0] == 2'b00) && (a < 32'd32);
    e.wr    = wr;
    e.err   = !lg;
    e.waits = int'(w);
    e.pulse = (wr && lg) ? (8'd1 << a[4:2]) : 8'd0;
    e.rdata = (!wr && lg) ? er : 32'd0;
    q.push_back(e);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr;
    PADDR = a; PWDATA = d; PSTRB = s; WaitCfg = w;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    if (chg) WaitCfg = 4'd0;
    for (int i = 0; i < 40; i++) begin
      @(negedge PCLK);
      if (PREADY) break;
    end
    if (!PREADY) chk("pready_timeout", 32'(PREADY), 32'd1);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  int         wcnt = 0;
  bit         pend = 1'b0;
  logic [7:0] pm = '0;

  // Monitor: checks every completion against the queue.
  always @(negedge PCLK) begin
    exp_t e;
    if (pend) begin
      chk("wrpulse", 32'(WrPulse), 32'(pm));
      pend = 1'b0;
    end
    if (!PRESETn || !PSEL) begin
      wcnt = 0;
    end else if (PREADY) begin
      if (q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_pready: got 1 want 0");
      end else begin
        e = q.pop_front();
        chk("pslverr", 32'(PSLVERR), 32'(e.err));
        if (!e.wr) chk("prdata", PRDATA, e.rdata);
        chk("wait_cycles", 32'(wcnt), 32'(e.waits));
        pm   = e.pulse;
        pend = 1'b1;
      end
      wcnt = 0;
    end else if (PENABLE) begin
      chk("wait_pslverr", 32'(PSLVERR), 32'd0);
      chk("wait_prdata", PRDATA, 32'd0);
      wcnt++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    logic [255:0] snap;

    repeat (2) @(posedge PCLK);
    #1;
    chk("rst_pready", 32'(PREADY), 32'd0);
    chk("rst_prdata", PRDATA, 32'd0);
    chk("rst_pslverr", 32'(PSLVERR), 32'd0);
    chk("rst_wrpulse", 32'(WrPulse), 32'd0);
    chk("rst_regfile", 32'(|RegFile), 32'd0);
    PRESETn = 1'b1;
    @(posedge PCLK); #1;

    t0 = cyc;
    xfer(1, 32'h04, 32'hDEADBEEF, 4'hF, 4'd0, 0, 32'h0);
    chk("zw_cycles", 32'(cyc - t0), 32'd2);
    xfer(0, 32'h04, 32'h0, 4'h0, 4'd0, 0, 32'hDEADBEEF);

    xfer(1, 32'h08, 32'h11223344, 4'hF, 4'd0, 0, 32'h0);
    xfer(1, 32'h08, 32'hAABBCCDD, 4'h5, 4'd0, 0, 32'h0);
    chk("strb_reg2", RegFile[64 +: 32], 32'h11BB33DD);
    xfer(0, 32'h08, 32'h0, 4'h0, 4'd0, 0, 32'h11BB33DD);

    t0 = cyc;
    xfer(0, 32'h00, 32'h0, 4'h0, 4'd3, 1, 32'h0);
    chk("ws3_cycles", 32'(cyc - t0), 32'd5);

    snap = RegFile;
    xfer(1, 32'h20, 32'hFFFFFFFF, 4'hF, 4'd0, 0, 32'h0);
    xfer(1, 32'h1000_0004, 32'hFFFFFFFF, 4'hF, 4'd0, 0, 32'h0);
    chk("err_nochange", 32'(RegFile != snap), 32'd0);
    xfer(0, 32'h02, 32'h0, 4'h0, 4'd1, 0, 32'h0);

    xfer(1, 32'h0C, 32'hFFFFFFFF, 4'h0, 4'd0, 0, 32'h0);
    chk("strb0_reg3", RegFile[96 +: 32], 32'h0);

    t0 = cyc;
    xfer(1, 32'h00, 32'h01234567, 4'hF, 4'd0, 0, 32'h0);
    xfer(1, 32'h04, 32'h89ABCDEF, 4'hF, 4'd0, 0, 32'h0);
    chk("b2b_cycles", 32'(cyc - t0), 32'd4);
    chk("b2b_reg0", RegFile[0 +: 32], 32'h01234567);
    chk("b2b_reg1", RegFile[32 +: 32], 32'h89ABCDEF);

    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1;
    PADDR = 32'h00; PWDATA = 32'hFFFFFFFF; PSTRB = 4'hF;
    repeat (2) begin
      @(negedge PCLK);
      chk("idle_penable_pready", 32'(PREADY), 32'd0);
    end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    chk("idle_penable_reg0", RegFile[0 +: 32], 32'h01234567);

    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
    PADDR = 32'h10; PWDATA = 32'hCAFEF00D; WaitCfg = 4'd2;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    @(negedge PCLK);
    chk("abort_wrpulse", 32'(WrPulse), 32'd0);
    chk("abort_reg4", RegFile[128 +: 32], 32'h0);
    @(posedge PCLK); #1;
    xfer(0, 32'h10, 32'h0, 4'h0, 4'd0, 0, 32'h0);

    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
    PADDR = 32'h0C; PWDATA = 32'h55AA55AA; PSTRB = 4'hF;
    WaitCfg = 4'd5;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    repeat (2) @(posedge PCLK);
    #1;
    PRESETn = 1'b0;
    #1;
    chk("rstmid_pready", 32'(PREADY), 32'd0);
    chk("rstmid_reg3", RegFile[96 +: 32], 32'h0);
    chk("rstmid_reg0", RegFile[0 +: 32], 32'h0);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PRESETn = 1'b1;
    @(posedge PCLK); #1;
    xfer(1, 32'h0C, 32'h12345678, 4'hF, 4'd0, 0, 32'h0);
    xfer(0, 32'h0C, 32'h0, 4'h0, 4'd0, 0, 32'h12345678);

    repeat (3) @(posedge PCLK);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
